// File: rtl/data_mem_strobe_bridge.sv
// data_mem_strobe_bridge
//   Converts core data-memory accesses (en/we/addr/wdata/strobe, held until
//   core_valid) into Controller read/write transactions. Partial-word stores
//   become a read-modify-write because the Controller has no byte strobes.
//   An optional per-transaction response timeout completes the access with
//   core_err=1.
//
// Ports
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   core_en/we/addr/wdata/strobe   core request (held until core_valid)
//   core_valid               one-cycle completion pulse
//   core_rdata               load data, valid with core_valid
//   core_err                 timeout flag, qualified by core_valid
//   mem_read, mem_write      Controller request levels (never both high)
//   mem_addr                 word-aligned address, stable per transaction
//   mem_wdata                Controller write data
//   mem_rdata, mem_response  Controller read data and single-cycle completion
module data_mem_strobe_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  core_en,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [31:0]           core_wdata,
  input  logic [3:0]            core_strobe,
  output logic                  core_valid,
  output logic [31:0]           core_rdata,
  output logic                  core_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_response
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              strobe_q, strobe_d;
  logic                    hold_q, hold_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    expired;

  logic                    core_valid_d;
  logic [31:0]             core_rdata_d;
  logic                    core_err_d;
  logic                    mem_read_d;
  logic                    mem_write_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic [31:0]             mem_wdata_d;

  // Byte offset bits are irrelevant to a word-wide Controller.
  logic unused_addr_bits;
  assign unused_addr_bits = ^core_addr[1:0];

  // Current cycle is the last one allowed without a response.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      wdata_q    <= '0;
      strobe_q   <= '0;
      hold_q     <= 1'b0;
      cnt_q      <= '0;
      core_valid <= 1'b0;
      core_rdata <= '0;
      core_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      wdata_q    <= wdata_d;
      strobe_q   <= strobe_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      core_valid <= core_valid_d;
      core_rdata <= core_rdata_d;
      core_err   <= core_err_d;
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    wdata_d      = wdata_q;
    strobe_d     = strobe_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    core_valid_d = 1'b0;
    core_rdata_d = core_rdata;
    core_err_d   = 1'b0;
    mem_read_d   = mem_read;
    mem_write_d  = mem_write;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;

    unique case (state_q)
      S_IDLE: begin
        if (core_en) begin
          mem_addr_d = {core_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d    = core_wdata;
          strobe_d   = core_strobe;
          cnt_d      = '0;
          if (!core_we) begin
            state_d    = S_RD;
            mem_read_d = 1'b1;
          end else if (core_strobe == 4'hF) begin
            state_d     = S_WR;
            mem_write_d = 1'b1;
            mem_wdata_d = core_wdata;
          end else if (core_strobe == 4'h0) begin
            // Spend one silent RESP cycle so an empty store has the same
            // latency as an access answered immediately.
            state_d = S_RESP;
            hold_d  = 1'b1;
          end else begin
            state_d    = S_RMW_RD;
            mem_read_d = 1'b1;
          end
        end
      end

      S_RD: begin
        if (mem_response) begin
          core_rdata_d = mem_rdata;
          mem_read_d   = 1'b0;
          core_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (expired) begin
          core_rdata_d = '0;
          mem_read_d   = 1'b0;
          core_valid_d = 1'b1;
          core_err_d   = 1'b1;
          state_d      = S_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RMW_RD: begin
        if (mem_response) begin
          // Merge: strobed lanes from the core, the rest from memory.
          for (int i = 0; i < 4; i++) begin
            mem_wdata_d[8*i +: 8] = strobe_q[i] ? wdata_q[8*i +: 8] : mem_rdata[8*i +: 8];
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_WR;
        end else if (expired) begin
          mem_read_d   = 1'b0;
          core_valid_d = 1'b1;
          core_err_d   = 1'b1;
          state_d      = S_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WR: begin
        if (mem_response) begin
          mem_write_d  = 1'b0;
          core_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (expired) begin
          mem_write_d  = 1'b0;
          core_valid_d = 1'b1;
          core_err_d   = 1'b1;
          state_d      = S_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (hold_q) begin
          hold_d       = 1'b0;
          core_valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_mem_strobe_bridge.sv
// Testbench for data_mem_strobe_bridge: directed accesses against a word
// memory model, per-cycle protocol checks, and a second instance with the
// timeout disabled.
module tb_data_mem_strobe_bridge;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rstn;
  always #5 clk = ~clk;

  logic        core_en, core_we, core_valid, core_err;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_strobe;
  logic        mem_read, mem_write, mem_response;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        z_en, z_we, z_valid, z_err, z_read, z_write, z_resp;
  logic [31:0] z_addr, z_wdata, z_rdata, z_maddr, z_mwdata, z_mrdata;
  logic [3:0]  z_strobe;

  data_mem_strobe_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .core_en(core_en), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_strobe(core_strobe),
    .core_valid(core_valid), .core_rdata(core_rdata), .core_err(core_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_response(mem_response)
  );

  data_mem_strobe_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nto (
    .i_clk(clk), .i_rstn(rstn),
    .core_en(z_en), .core_we(z_we), .core_addr(z_addr),
    .core_wdata(z_wdata), .core_strobe(z_strobe),
    .core_valid(z_valid), .core_rdata(z_rdata), .core_err(z_err),
    .mem_read(z_read), .mem_write(z_write), .mem_addr(z_maddr),
    .mem_wdata(z_mwdata), .mem_rdata(z_mrdata), .mem_response(z_resp)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [0:255];
  logic [31:0] last_rd;
  int          resp_wait;
  bit          resp_on;
  int          wcnt;

  bit          exp_pending = 1'b0;
  logic [31:0] exp_addr, exp_wdata;
  int          rd_hi, rd_rise, wr_rise;
  logic        prev_rd, prev_wr;
  logic [31:0] wdata_at_resp;
  int          got_lat;
  logic [31:0] got_rdata;
  logic        got_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Controller model: answers after resp_wait idle cycles from the word memory.
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_response = 1'b0;
      mem_rdata    = '0;
      wcnt         = 0;
    end else begin
      mem_response = 1'b0;
      if (mem_read || mem_write) begin
        if (resp_on && wcnt == resp_wait) begin
          mem_response = 1'b1;
          mem_rdata    = ref_mem[mem_addr[9:2]];
          if (mem_write) wdata_at_resp = mem_wdata;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Per-cycle protocol checks and activity counters.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("rw_exclusive", 32'(mem_read && mem_write), 32'd0);
      if (!core_valid) chk("err_unqualified", 32'(core_err), 32'd0);
      if (!exp_pending) chk("spurious_valid", 32'(core_valid), 32'd0);
      if (mem_read || mem_write) chk("mem_addr", mem_addr, exp_addr);
      if (mem_write) chk("mem_wdata", mem_wdata, exp_wdata);
      if (mem_read) rd_hi++;
      if (mem_read && !prev_rd) rd_rise++;
      if (mem_write && !prev_wr) wr_rise++;
      prev_rd = mem_read;
      prev_wr = mem_write;
    end else begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end
  end

  // One core access: expectations come from the word-memory model.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int w, input bit on);
    bit          partial, zero, to, got;
    int          lat, k;
    logic [7:0]  idx;
    logic [31:0] old, merged, exp_rd;
    partial = we && strb != 4'h0 && strb != 4'hF;
    zero    = we && strb == 4'h0;
    to      = (T > 0) && !zero && (!on || w >= int'(T));
    idx     = addr[9:2];
    old     = ref_mem[idx];
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    lat     = zero ? 2 : (to ? int'(T) + 1 : (partial ? 2*w + 3 : w + 2));
    exp_rd  = !we ? (to ? 32'h0 : old) : last_rd;
    @(negedge clk);
    exp_addr  = {addr[31:2], 2'b00};
    exp_wdata = merged;
    resp_wait = w;
    resp_on   = on;
    rd_hi = 0; rd_rise = 0; wr_rise = 0;
    exp_pending = 1'b1;
    core_en = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; core_strobe = strb;
    got = 1'b0; k = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (core_valid) got = 1'b1;
    end
    if (!got) begin
      chk("no_completion", 32'd0, 32'd1);
    end else begin
      got_lat = k; got_rdata = core_rdata; got_err = core_err;
      chk("latency", 32'(k), 32'(lat));
      chk("core_err", 32'(core_err), 32'(to));
      chk("core_rdata", core_rdata, exp_rd);
    end
    core_en = 1'b0;
    @(posedge clk);
    exp_pending = 1'b0;
    chk("read_txns", 32'(rd_rise), 32'((!we || partial) ? 1 : 0));
    chk("write_txns", 32'(wr_rise), 32'((we && !zero && !(partial && to)) ? 1 : 0));
    if (we && !zero && !to) ref_mem[idx] = merged;
    if (!we) last_rd = exp_rd;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5A50000;
    ref_mem[8'h41] = 32'hCAFEBABE;
    last_rd = '0;
    resp_wait = 0; resp_on = 1'b1;
    core_en = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_strobe = '0;
    z_en = 0; z_we = 0; z_addr = '0; z_wdata = '0; z_strobe = '0; z_resp = 0; z_mrdata = '0;
    exp_addr = '0; exp_wdata = '0; wdata_at_resp = '0;
    rdrstn_init();

    // Reset state.
    #23;
    chk("rst_valid", 32'(core_valid), 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_err", 32'(core_err), 32'd0);
    chk("rst_read", 32'(mem_read), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Read with 3 wait cycles.
    access(1'b0, 32'h104, 32'h0, 4'h0, 3, 1'b1);
    chk("lit_read_hi", 32'(rd_hi), 32'd4);
    chk("lit_read_data", got_rdata, 32'hCAFEBABE);

    // Full-word write.
    access(1'b1, 32'h200, 32'h11223344, 4'hF, 1, 1'b1);
    chk("lit_full_wdata", wdata_at_resp, 32'h11223344);

    // Byte write by read-modify-write.
    ref_mem[8'h80] = 32'h55667788;
    access(1'b1, 32'h202, 32'h00AB0000, 4'b0100, 2, 1'b1);
    chk("lit_rmw_wdata", wdata_at_resp, 32'h55AB7788);

    // Empty store.
    access(1'b1, 32'h010, 32'hFFFFFFFF, 4'h0, 0, 1'b1);
    chk("lit_zero_lat", 32'(got_lat), 32'd2);

    // Unanswered read times out; response on the last cycle wins.
    access(1'b0, 32'h108, 32'h0, 4'h0, 0, 1'b0);
    chk("lit_to_err", 32'(got_err), 32'd1);
    chk("lit_to_rdata", got_rdata, 32'h0);
    chk("lit_to_read_hi", 32'(rd_hi), 32'd8);
    access(1'b0, 32'h108, 32'h0, 4'h0, 7, 1'b1);
    chk("lit_edge_err", 32'(got_err), 32'd0);

    // Mixed accesses against the model.
    access(1'b0, 32'h200, 32'h0, 4'h0, 0, 1'b1);
    access(1'b1, 32'h020, 32'hDEADBEEF, 4'b1001, 0, 1'b1);
    access(1'b0, 32'h023, 32'h0, 4'h0, 1, 1'b1);
    access(1'b1, 32'h030, 32'h12345678, 4'hF, 0, 1'b0);
    access(1'b1, 32'h040, 32'h00CC0000, 4'b0110, 0, 1'b0);

    // Reset during the write phase of a read-modify-write.
    @(negedge clk);
    exp_addr = 32'h300;
    exp_wdata = {ref_mem[8'hC0][31:8], 8'h5A};
    resp_wait = 4; resp_on = 1'b1;
    exp_pending = 1'b1;
    core_en = 1'b1; core_we = 1'b1; core_addr = 32'h300; core_wdata = 32'h0000005A; core_strobe = 4'b0001;
    for (int k = 0; k < 50 && !mem_write; k++) @(negedge clk);
    chk("rmw_reached_wr", 32'(mem_write), 32'd1);
    @(negedge clk);
    #2 rstn = 1'b0;
    core_en = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(core_valid), 32'd0);
    chk("mid_rst_read", 32'(mem_read), 32'd0);
    chk("mid_rst_write", 32'(mem_write), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_rdata", core_rdata, 32'd0);
    exp_pending = 1'b0;
    last_rd = '0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    access(1'b0, 32'h104, 32'h0, 4'h0, 0, 1'b1);
    chk("lit_post_rst_read", got_rdata, 32'hCAFEBABE);

    // Timeout disabled: a long wait is not an error.
    @(negedge clk);
    z_en = 1'b1; z_we = 1'b0; z_addr = 32'h104;
    begin
      int zr, zv;
      zr = 0; zv = 0;
      repeat (20) begin
        @(negedge clk);
        if (z_read) zr++;
        if (z_valid) zv++;
      end
      chk("nto_read_held", 32'(zr), 32'd20);
      chk("nto_no_valid", 32'(zv), 32'd0);
    end
    z_mrdata = 32'hDEADBEEF; z_resp = 1'b1;
    @(negedge clk);
    z_resp = 1'b0;
    chk("nto_read_drop", 32'(z_read), 32'd0);
    chk("nto_valid", 32'(z_valid), 32'd1);
    chk("nto_err", 32'(z_err), 32'd0);
    chk("nto_rdata", z_rdata, 32'hDEADBEEF);
    z_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic rdrstn_init();
    rstn = 1'b0;
  endtask

  // Global guard so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_strobe_bridge.md
Name: data_mem_strobe_bridge

Overview:
- Sits between the aukv core data-memory port (en/we/addr/data/strobe/valid) and the Controller's data-memory port (separate read/write requests, response, no byte strobes).
- Converts each core access into Controller read or write transactions.
- Implements partial-word stores by read-modify-write, since the Controller has no strobe input.
- Adds an optional response timeout with an error flag.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- TIMEOUT_CYCLES, 0, maximum cycles to wait for mem_response per memory transaction; 0 disables the timeout.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  asynchronous active-low reset
- core_en  input  1  access request from core, held until core_valid
- core_we  input  1  1 = write, 0 = read
- core_addr  input  ADDR_WIDTH  byte address
- core_wdata  input  32  store data, byte lanes already aligned
- core_strobe  input  4  byte-lane write enables
- core_valid  output  1  one-cycle completion pulse
- core_rdata  output  32  load data, valid while core_valid=1
- core_err  output  1  timeout flag, qualified by core_valid
- mem_read  output  1  Controller read request, level
- mem_write  output  1  Controller write request, level
- mem_addr  output  ADDR_WIDTH  word-aligned address {core_addr[ADDR_WIDTH-1:2],2'b00}
- mem_wdata  output  32  write data to Controller
- mem_rdata  input  32  read data from Controller
- mem_response  input  1  Controller completion, single cycle

Behaviour:
- Reset: asynchronous, active-low. All outputs go to 0; FSM goes to IDLE; timeout counter clears. Any in-flight transaction is abandoned and no completion is issued afterwards.
- All outputs are registered.
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: when core_en=1, latch addr, we, wdata and strobe, then branch:
  - we=0 -> RD.
  - we=1, strobe=4'hF -> WR, with mem_wdata=core_wdata.
  - we=1, strobe=4'h0 -> RESP directly, with no memory access and core_err=0.
  - Otherwise -> RMW_RD.
- RD: mem_read=1 from the cycle after acceptance. On mem_response=1: capture mem_rdata into core_rdata, drop mem_read on the same edge, go to RESP.
- RMW_RD: mem_read=1. On mem_response=1: mem_wdata[8i+7:8i] = strobe[i] ? wdata byte i : mem_rdata byte i. Drop mem_read and raise mem_write on the same edge; go to WR.
- WR: mem_write=1 until mem_response=1, then drop it and go to RESP. core_rdata is not updated by writes.
- RESP: core_valid=1 for exactly one cycle, then IDLE.
  - core_en is ignored in RESP and in all busy states.
  - A new request can be accepted in the IDLE cycle after RESP.
- mem_read and mem_write are never both 1.
- mem_addr is stable for the whole transaction.
- mem_response while in IDLE or RESP is ignored.
- Latency:
  - Read, and full or zero-strobe write: core_valid 2 cycles after acceptance plus Controller wait cycles.
  - Partial write: two memory transactions plus RESP.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on entering RD, RMW_RD or WR and counts each cycle without mem_response.
  - When count reaches TIMEOUT_CYCLES: drop mem_read/mem_write, go to RESP with core_err=1. On a read, core_rdata=0. On a partial write, no write is issued.
  - A mem_response arriving in the same cycle as expiry wins: normal completion, core_err=0.
- core_err is 0 whenever core_valid=0.

Test Plan:
- Read at 0x104, Controller responds with 0xCAFEBABE after 3 wait cycles -> mem_read high 4 cycles, mem_addr=0x104; core_valid pulse one cycle later with core_rdata=0xCAFEBABE, core_err=0.
- Full write 0x11223344 to 0x200 -> single mem_write transaction with mem_wdata=0x11223344, no mem_read; one core_valid pulse.
- Byte write: strobe=4'b0100, wdata=0x00AB0000, addr 0x202, memory holds 0x55667788 -> read then write at 0x200, mem_wdata=0x55AB7788, mem_read/mem_write never overlap.
- strobe=0 write -> core_valid 2 cycles after acceptance, no mem_read or mem_write activity.
- TIMEOUT_CYCLES=8, read never answered -> mem_read drops after 8 cycles; core_valid=1, core_err=1, core_rdata=0. Repeat with mem_response on cycle 8 -> normal completion, core_err=0.
- Assert i_rstn=0 mid-RMW (in WR) -> all outputs 0 immediately; no core_valid after release; next read completes normally.
